// File: rtl/alarm_pkg.sv
// Shared types for the alarm-clock keypad front end: key codes, scanner states
// and the row/column to digit decode.
package alarm_pkg;

   localparam int unsigned KEY_W = 4;
   localparam int unsigned ROW_W = 4;
   localparam int unsigned COL_W = 3;

   typedef logic [KEY_W-1:0] key_code_t;

   localparam key_code_t NOKEY = 4'd10;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   // Digit for one low row on the given column; * , # and multi-row presses give NOKEY.
   function automatic key_code_t decode_key(input logic [1:0] col_idx,
                                            input logic [ROW_W-1:0] srow);
      key_code_t code;
      code = NOKEY;
      if (col_idx <= 2'd2) begin
         case (srow)
            4'b1110: code = key_code_t'(int'(col_idx) + 1);
            4'b1101: code = key_code_t'(int'(col_idx) + 4);
            4'b1011: code = key_code_t'(int'(col_idx) + 7);
            4'b0111: code = (col_idx == 2'd1) ? 4'd0 : NOKEY;
            default: code = NOKEY;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones (idle for active-low lines).
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock) begin
      if (!reset) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad column scanner with press/release debounce; emits a held digit
// code and a one-cycle pulse when a new digit is accepted.
module keypad_scanner
   import alarm_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 256,
   parameter int unsigned DEBOUNCE_CNT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output key_code_t        key,
   output logic             key_press
);

   localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_CNT);
   localparam logic [COL_W-1:0]  COL_RESET = 3'b110;

   logic [ROW_W-1:0]  srow;
   logic [SLOT_W-1:0] slot;
   scan_state_t       state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   key_code_t         code, code_n;
   key_code_t         key_n;
   logic              key_press_n;
   logic [COL_W-1:0]  col_n;
   logic [1:0]        col_idx;
   logic              sample;
   key_code_t         cand;
   logic              cand_valid;
   logic              match;

   sync_2ff #(.WIDTH(ROW_W)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (row),
      .q     (srow)
   );

   assign sample     = (slot == SLOT_LAST);
   assign cand       = decode_key(col_idx, srow);
   assign cand_valid = (cand != NOKEY);
   assign match      = cand_valid && (cand == code);

   always_comb begin
      case (col)
         3'b101:  col_idx = 2'd1;
         3'b011:  col_idx = 2'd2;
         default: col_idx = 2'd0;
      endcase
   end

   // Next-state and output decisions happen only on the sampling slot.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      code_n      = code;
      key_n       = key;
      key_press_n = 1'b0;
      col_n       = col;
      if (sample) begin
         case (state)
            SCAN: begin
               if (cand_valid) begin
                  code_n = cand;
                  cnt_n  = CNT_W'(1);
                  if (cnt_n == CNT_DONE) begin
                     state_n     = HELD;
                     key_n       = cand;
                     key_press_n = 1'b1;
                  end else begin
                     state_n = DEBOUNCE;
                  end
               end else begin
                  col_n = {col[1:0], col[2]};
               end
            end
            DEBOUNCE: begin
               if (match) begin
                  cnt_n = cnt + CNT_W'(1);
                  if (cnt_n == CNT_DONE) begin
                     state_n     = HELD;
                     key_n       = code;
                     key_press_n = 1'b1;
                  end
               end else begin
                  state_n = SCAN;
                  cnt_n   = '0;
               end
            end
            HELD: begin
               if (!match) begin
                  cnt_n = CNT_W'(1);
                  if (cnt_n == CNT_DONE) begin
                     state_n = SCAN;
                     cnt_n   = '0;
                     key_n   = NOKEY;
                     col_n   = {col[1:0], col[2]};
                  end else begin
                     state_n = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (match) begin
                  state_n = HELD;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
                  if (cnt_n == CNT_DONE) begin
                     state_n = SCAN;
                     cnt_n   = '0;
                     key_n   = NOKEY;
                     col_n   = {col[1:0], col[2]};
                  end
               end
            end
            default: begin
               state_n = SCAN;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= SCAN;
         slot      <= '0;
         cnt       <= '0;
         code      <= NOKEY;
         key       <= NOKEY;
         key_press <= 1'b0;
         col       <= COL_RESET;
      end else begin
         state     <= state_n;
         slot      <= sample ? '0 : slot + SLOT_W'(1);
         cnt       <= cnt_n;
         code      <= code_n;
         key       <= key_n;
         key_press <= key_press_n;
         col       <= col_n;
      end
   end

endmodule
